// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data-memory bus between the pipeline and the responder.
//   master (pipeline)  : drives MemRead, MemWrite, addr, wdata; observes rdata, rvalid, err, mem_stall
//   slave  (responder) : the reverse
// Signal names follow the pipeline's existing EX/MEM naming.
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        mem_stall;

  modport master (
    output MemRead, MemWrite, addr, wdata,
    input  rdata, rvalid, err, mem_stall
  );

  modport slave (
    input  MemRead, MemWrite, addr, wdata,
    output rdata, rvalid, err, mem_stall
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-organised data memory for the 5-stage MIPS32 pipeline.
// Accepts one load/store in IDLE, waits LATENCY cycles in BUSY, then reports completion
// for one cycle in DONE. mem_stall freezes the pipeline from the request cycle until DONE.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   bus        dmem_responder_if.slave
//                MemRead/MemWrite/addr/wdata in; rdata/rvalid/err registered out;
//                mem_stall combinational out
module dmem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  // Configuration checks at elaboration.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY=%0d outside legal range 1..15", LATENCY);
  end
  if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
    $error("dmem_responder: ADDR_W=%0d outside legal range 1..30", ADDR_W);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              is_wr_q;
  logic              mis_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  logic              req_c;
  logic              access_c;
  logic              we_c;

  // Upper address bits alias onto the array; they are deliberately dropped.
  if (ADDR_W + 2 < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
  end

  assign req_c    = bus.MemRead | bus.MemWrite;
  assign access_c = (state_q == BUSY) && (cnt_q == '0);
  // Aligned stores only; a reset on the access edge abandons the write.
  assign we_c     = access_c && is_wr_q && !mis_q && !reset;

  // Stall starts combinationally in the request cycle so the pipeline freezes at once.
  assign bus.mem_stall = ((state_q == IDLE) && req_c) || (state_q == BUSY);
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;

  // Memory array write port; contents are never reset.
  always_ff @(posedge clock) begin
    if (we_c) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Control FSM with registered completion outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_c) begin
            idx_q   <= bus.addr[ADDR_W+1:2];
            wdata_q <= bus.wdata;
            // A simultaneous load and store is handled as a store.
            is_wr_q <= bus.MemWrite;
            mis_q   <= (bus.addr[1:0] != 2'b00);
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q  <= DONE;
            rvalid_q <= 1'b1;
            err_q    <= mis_q;
            // Stores and misaligned accesses return zero.
            rdata_q  <= (is_wr_q || mis_q) ? 32'h0 : mem[idx_q];
          end
        end
        DONE: begin
          // Pipeline advances on this edge; the still-present request is not re-accepted.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder.
// Two instances: LATENCY=2 (directed scenarios + random) and LATENCY=1 (timing + random).
module tb_dmem_responder;

  localparam int unsigned AW = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst [2];
  logic        mr  [2];
  logic        mw  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic        st  [2];

  int          checks;
  int          errors;
  int          cyc;
  exp_t        sb0 [$];
  exp_t        sb1 [$];
  logic [31:0] last_rd [2];
  logic [31:0] mdl [2][1 << AW];

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.MemRead  = mr[0];
  assign bus0.MemWrite = mw[0];
  assign bus0.addr     = ad[0];
  assign bus0.wdata    = wd[0];
  assign bus1.MemRead  = mr[1];
  assign bus1.MemWrite = mw[1];
  assign bus1.addr     = ad[1];
  assign bus1.wdata    = wd[1];
  assign st[0]         = bus0.mem_stall;
  assign st[1]         = bus1.mem_stall;

  dmem_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut0 (
    .clock (clk),
    .reset (rst[0]),
    .bus   (bus0)
  );

  dmem_responder #(.ADDR_W(AW), .LATENCY(1)) u_dut1 (
    .clock (clk),
    .reset (rst[1]),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(int id);
    return (id == 0) ? 2 : 1;
  endfunction

  task automatic chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops an expectation on each completion, checks hold otherwise.
  task automatic check_out(int id, logic rst_v, logic rv, logic [31:0] rd, logic e_v);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (rst_v) begin
      if (id == 0) sb0.delete(); else sb1.delete();
      last_rd[id] = 32'h0;
      return;
    end
    if (rv === 1'b1) begin
      if (id == 0 && sb0.size() != 0) begin e = sb0.pop_front(); have = 1'b1; end
      if (id == 1 && sb1.size() != 0) begin e = sb1.pop_front(); have = 1'b1; end
      if (!have) begin
        chk(1'b0, $sformatf("unexpected_rvalid[%0d]", id), 32'(rv), 32'h0);
      end else begin
        chk(rd === e.rdata, $sformatf("rdata[%0d]", id), rd, e.rdata);
        chk(e_v === e.err, $sformatf("err[%0d]", id), 32'(e_v), 32'(e.err));
        chk(cyc == e.cyc, $sformatf("rvalid_cycle[%0d]", id), 32'(cyc), 32'(e.cyc));
        last_rd[id] = e.rdata;
      end
    end else begin
      chk(rd === last_rd[id], $sformatf("rdata_hold[%0d]", id), rd, last_rd[id]);
      chk(e_v === 1'b0, $sformatf("err_idle[%0d]", id), 32'(e_v), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    check_out(0, rst[0], bus0.rvalid, bus0.rdata, bus0.err);
    check_out(1, rst[1], bus1.rvalid, bus1.rdata, bus1.err);
  end

  // Issue one request, hold it through the stall and the completion cycle, then release.
  task automatic req(int id, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    exp_t e;
    int   idx;
    bit   mis;
    int   n;
    idx = int'(a[AW+1:2]);
    mis = (a[1:0] != 2'b00);
    @(posedge clk); #1;
    mr[id] = rd;
    mw[id] = wr;
    ad[id] = a;
    wd[id] = d;
    e.cyc = cyc + lat_of(id) + 1;
    e.err = mis;
    if (wr) begin
      e.rdata = 32'h0;
      if (!mis) mdl[id][idx] = d;
    end else begin
      e.rdata = mis ? 32'h0 : mdl[id][idx];
    end
    if (id == 0) sb0.push_back(e); else sb1.push_back(e);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (st[id] !== 1'b1) break;
      n++;
    end
    chk(n == lat_of(id) + 1, $sformatf("stall_cycles[%0d]", id), 32'(n), 32'(lat_of(id) + 1));
    @(posedge clk); #1;
    mr[id] = 1'b0;
    mw[id] = 1'b0;
  endtask

  // Store that is abandoned by a reset in its last BUSY cycle (LATENCY=2 instance).
  task automatic reset_mid_store(logic [31:0] a, logic [31:0] d);
    @(posedge clk); #1;
    mw[0] = 1'b1;
    ad[0] = a;
    wd[0] = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    mw[0]  = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk(bus0.rvalid === 1'b0, "rst_mid_rvalid", 32'(bus0.rvalid), 32'h0);
    chk(bus0.rdata === 32'h0, "rst_mid_rdata", bus0.rdata, 32'h0);
    chk(bus0.mem_stall === 1'b0, "rst_mid_idle_stall", 32'(bus0.mem_stall), 32'h0);
  endtask

  task automatic rand_req(int id);
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    a  = $urandom;
    d  = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    op = $urandom_range(0, 4);
    case (op)
      0, 1:    req(id, 1'b1, 1'b0, a, d);
      2, 3:    req(id, 1'b0, 1'b1, a, d);
      default: req(id, 1'b1, 1'b1, a, d);
    endcase
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i]     = 1'b1;
      mr[i]      = 1'b0;
      mw[i]      = 1'b0;
      ad[i]      = 32'h0;
      wd[i]      = 32'h0;
      last_rd[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk(bus0.rdata === 32'h0, "reset_rdata", bus0.rdata, 32'h0);
    chk(bus0.rvalid === 1'b0, "reset_rvalid", 32'(bus0.rvalid), 32'h0);
    chk(bus0.err === 1'b0, "reset_err", 32'(bus0.err), 32'h0);
    chk(bus0.mem_stall === 1'b0, "reset_stall", 32'(bus0.mem_stall), 32'h0);
    chk(bus1.rdata === 32'h0, "reset_rdata1", bus1.rdata, 32'h0);
    chk(bus1.mem_stall === 1'b0, "reset_stall1", 32'(bus1.mem_stall), 32'h0);

    // Give every word a known value so any later load has a defined expectation.
    for (int id = 0; id < 2; id++) begin
      for (int w = 0; w < (1 << AW); w++) begin
        req(id, 1'b0, 1'b1, 32'(w) << 2, $urandom);
      end
    end

    // Directed scenarios on the LATENCY=2 instance.
    req(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    req(0, 1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678);
    req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    req(0, 1'b0, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF);
    req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    req(0, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    reset_mid_store(32'h0000_0030, 32'h0000_0001);
    req(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
    req(0, 1'b1, 1'b0, 32'hFFFF_FC31, 32'h0);

    // LATENCY=1 instance: two-cycle stall, completion at T+2.
    req(1, 1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_F00D);
    req(1, 1'b1, 1'b0, 32'h0000_0444, 32'h0);

    for (int n = 0; n < 150; n++) begin
      rand_req(0);
      rand_req(1);
    end

    repeat (5) @(posedge clk);
    chk(sb0.size() == 0, "sb0_drained", 32'(sb0.size()), 32'h0);
    chk(sb1.size() == 0, "sb1_drained", 32'(sb1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
